mdu_seq: RTL and testbench
==========================

# mdu_seq

Iterative multiply/divide sequencer for the RV32M group (mul, mulh, mulhsu, mulhu, div, divu, rem, remu) produced by the 32-bit instruction decoder. It owns a single shared shift-add/shift-subtract datapath and runs it over multiple cycles. It presents a valid/ready handshake to the execute stage on both the operand side and the result side. It also handles the RISC-V sign, divide-by-zero and overflow corner cases in hardware.

## Interface
- XLEN, 32, operand/result width; iteration count equals XLEN
- CNT_W, $clog2(XLEN+1), iteration counter width
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- flush  in  1  synchronous abort; returns to IDLE next edge, discards any operation or held result
- in_valid  in  1  operands/op valid
- in_ready  out  1  high only in IDLE
- op  in  3  funct3 of the M instruction: 0 mul, 1 mulh, 2 mulhsu, 3 mulhu, 4 div, 5 divu, 6 rem, 7 remu
- rs1  in  XLEN  first operand (multiplicand/dividend)
- rs2  in  XLEN  second operand (multiplier/divisor)
- out_valid  out  1  result valid, held until accepted
- out_ready  in  1  consumer accepts result
- result  out  XLEN  result; stable while out_valid

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE: in_ready=1. If in_valid, latch op, rs1, rs2 and classify:
  - Div op with rs2==0 goes to DONE. div/divu give all-ones; rem/remu give rs1.
  - div/rem with rs1==0x8000_0000 and rs2==0xFFFF_FFFF goes to DONE. div gives 0x8000_0000; rem gives 0.
  - Otherwise latch operand magnitudes and result sign, clear counter, go to CALC.
- Operand signedness:
  - mul, mulh, div, rem: both operands signed.
  - mulhsu: rs1 signed, rs2 unsigned.
  - mulhu, divu, remu: both unsigned.
  - Magnitude = two's-complement negate when signed and MSB set.
- CALC, multiply: 2·XLEN accumulator. Each cycle, if the current multiplier LSB is 1, add the multiplicand into the upper half. Then shift right by 1, carry included.
- CALC, divide: restoring division. Each cycle, shift {rem, quot} left by 1. Trial-subtract the divisor from rem. If there is no borrow, commit the subtraction and set the quot LSB.
- CALC lasts exactly XLEN cycles, with the counter running 0..XLEN-1. Then go to FIX.
- FIX: negate the 2·XLEN product if signs differ (multiply); negate quot if signs differ (div); negate rem if the dividend was negative (rem). Select the output:
  - mul: low half.
  - mulh/mulhsu/mulhu: high half.
  - div/divu: quot.
  - rem/remu: rem.
  - Then go to DONE.
- DONE: out_valid=1. When out_ready, go to IDLE.
- flush has priority over every transition in every state.
- in_valid outside IDLE is ignored; in_ready=0 there.

## Timing
- Reset (rstn low, asynchronous) sets:
  - state=IDLE, in_ready=1, out_valid=0, result=0.
  - Counter and all operand/accumulator registers = 0.
- Normal op latency: accept at edge E; CALC occupies edges E+1..E+XLEN; FIX at edge E+XLEN+1. out_valid is high after edge E+XLEN+1, which is 33 edges for XLEN=32.
- Special-case latency: out_valid is high after edge E+1.
- in_ready and out_valid are never high in the same cycle.
- Minimum spacing between accepts is latency+1 cycles, because the DONE→IDLE edge is required. There is no accept in the same cycle as the result handshake.
- Backpressure: with out_ready low, DONE holds indefinitely with result constant.
- Reset asserted mid-CALC takes effect immediately, without waiting for a clock edge.
- flush in the same cycle as in_valid&&in_ready: the operation is not accepted and the state stays IDLE.
- flush in the same cycle as out_valid&&out_ready: go to IDLE; the consumer treats the result as dropped.

## Test plan
- mul 7 × 0xFFFF_FFFD (−3) → result 0xFFFF_FFEB, out_valid 33 edges after accept. mulhu 0xFFFF_FFFF × 0xFFFF_FFFF → 0xFFFF_FFFE.
- mulh 0x8000_0000 × 0x8000_0000 → 0x4000_0000. mulhsu 0xFFFF_FFFF (−1) × 0xFFFF_FFFF → 0xFFFF_FFFF.
- div 0xFFFF_FFF9 (−7) / 2 → 0xFFFF_FFFD. rem of the same operands → 0xFFFF_FFFF. divu 100 / 7 → 14. remu → 2.
- divu 5 / 0 → 0xFFFF_FFFF and remu 5 / 0 → 5, each with out_valid one edge after accept. div 0x8000_0000 / 0xFFFF_FFFF → 0x8000_0000. rem of the same operands → 0.
- Backpressure and handshake:
  - Hold out_ready low 10 cycles after out_valid: result is stable and in_ready stays 0.
  - Raise out_ready: one-cycle handshake, then in_ready=1 the next cycle.
  - A new in_valid presented during DONE is not accepted.
- Abort and reset:
  - Assert flush on the 10th CALC cycle: IDLE next edge, out_valid never rises, and the next op completes correctly.
  - Repeat with rstn pulsed low asynchronously mid-CALC: all outputs are at reset values while rstn is low.

Source files
------------

// File: rtl/mdu_seq_if.sv
// Handshake bundle between execute stage and the RV32M sequencer.
// Operand side: in_valid/in_ready/op/rs1/rs2; result side: out_valid/out_ready/result.
interface mdu_seq_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;

  modport master (
    output in_valid, op, rs1, rs2, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, op, rs1, rs2, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/mdu_seq.sv
// Iterative RV32M multiply/divide sequencer sharing one shift-add/subtract datapath.
// Ports: clk, rstn (async low), flush (sync abort), bus (mdu_seq_if.slave handshake).
module mdu_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN+1)
) (
  input  logic      clk,
  input  logic      rstn,
  input  logic      flush,
  mdu_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t            r_state;
  state_t            w_state_n;
  logic [2:0]        r_op;
  logic [CNT_W-1:0]  r_cnt;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_d;
  logic [XLEN-1:0]   r_result;
  logic              r_neg_q;
  logic              r_neg_r;
  logic              r_special;

  logic              w_accept;
  logic              w_div;
  logic              w_zero;
  logic              w_ovf;
  logic              w_special;
  logic [XLEN-1:0]   w_spec_res;
  logic              w_sa;
  logic              w_sb;
  logic              w_na;
  logic              w_nb;
  logic [XLEN-1:0]   w_ma;
  logic [XLEN-1:0]   w_mb;
  logic [XLEN:0]     w_sum;
  logic [2*XLEN-1:0] w_mul_step;
  logic [XLEN+1:0]   w_trial;
  logic              w_borrow;
  logic [2*XLEN-1:0] w_div_step;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quot;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_fix_res;

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.result    = r_result;

  assign w_accept = bus.in_valid && (r_state == IDLE) && !flush;

  assign w_div     = bus.op[2];
  assign w_zero    = (bus.rs2 == '0);
  assign w_ovf     = bus.op[2] && !bus.op[0]
                     && (bus.rs1 == MIN_NEG)
                     && (bus.rs2 == '1);
  assign w_special = w_div && (w_zero || w_ovf);

  always_comb begin
    w_spec_res = '0;
    if (w_zero) begin
      w_spec_res = bus.op[1] ? bus.rs1 : '1;
    end else begin
      w_spec_res = bus.op[1] ? '0 : MIN_NEG;
    end
  end

  always_comb begin
    w_sa = 1'b0;
    w_sb = 1'b0;
    case (bus.op)
      3'd0, 3'd1, 3'd4, 3'd6: begin
        w_sa = 1'b1;
        w_sb = 1'b1;
      end
      3'd2: w_sa = 1'b1;
      default: ;
    endcase
  end

  assign w_na = w_sa && bus.rs1[XLEN-1];
  assign w_nb = w_sb && bus.rs2[XLEN-1];
  assign w_ma = w_na ? (~bus.rs1 + 1'b1) : bus.rs1;
  assign w_mb = w_nb ? (~bus.rs2 + 1'b1) : bus.rs2;

  // Multiply: add multiplicand into the upper half, then shift the
  // whole accumulator right with the carry moving into the top bit.
  assign w_sum = {1'b0, r_acc[2*XLEN-1:XLEN]}
               + (r_acc[0] ? {1'b0, r_d} : '0);
  assign w_mul_step = {w_sum, r_acc[XLEN-1:1]};

  // Divide: the shifted remainder needs XLEN+1 bits before the trial.
  assign w_trial  = {1'b0, r_acc[2*XLEN-1:XLEN-1]}
                  - {2'b00, r_d};
  assign w_borrow = w_trial[XLEN+1];
  assign w_div_step = w_borrow
    ? {r_acc[2*XLEN-2:0], 1'b0}
    : {w_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

  assign w_prod = r_neg_q ? (~r_acc + 1'b1) : r_acc;
  assign w_quot = r_neg_q ? (~r_acc[XLEN-1:0] + 1'b1)
                          : r_acc[XLEN-1:0];
  assign w_rem  = r_neg_r ? (~r_acc[2*XLEN-1:XLEN] + 1'b1)
                          : r_acc[2*XLEN-1:XLEN];

  always_comb begin
    w_fix_res = '0;
    case (r_op)
      3'd0:             w_fix_res = w_prod[XLEN-1:0];
      3'd1, 3'd2, 3'd3: w_fix_res = w_prod[2*XLEN-1:XLEN];
      3'd4, 3'd5:       w_fix_res = w_quot;
      default:          w_fix_res = w_rem;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_state_n;
  end

  // Corner cases resolve in IDLE but still pass through FIX, so they
  // answer one edge after the accept rather than on the accept edge.
  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      IDLE: if (bus.in_valid) w_state_n = w_special ? FIX : CALC;
      CALC: if (r_cnt == CNT_W'(XLEN-1)) w_state_n = FIX;
      FIX:  w_state_n = DONE;
      DONE: if (bus.out_ready) w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
    if (flush) w_state_n = IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_op      <= '0;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_d       <= '0;
      r_result  <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_special <= 1'b0;
    end else if (!flush) begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op      <= bus.op;
            r_cnt     <= '0;
            r_special <= w_special;
            if (w_special) begin
              r_result <= w_spec_res;
            end else begin
              r_neg_q <= w_na ^ w_nb;
              r_neg_r <= w_na;
              r_d     <= w_div ? w_mb : w_ma;
              r_acc   <= {{XLEN{1'b0}}, (w_div ? w_ma : w_mb)};
            end
          end
        end
        CALC: begin
          r_cnt <= r_cnt + CNT_W'(1);
          r_acc <= r_op[2] ? w_div_step : w_mul_step;
        end
        FIX: begin
          if (!r_special) r_result <= w_fix_res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Directed testbench for mdu_seq: vector table plus handshake,
// backpressure, flush and asynchronous-reset sequences.
module tb_mdu_seq;

  logic clk;
  logic rstn;
  logic flush;
  int   checks;
  int   failures;

  mdu_seq_if #(.XLEN(32)) bus ();

  mdu_seq #(.XLEN(32)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t tv[15];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b);
    bus.op       = op;
    bus.rs1      = a;
    bus.rs2      = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat, output bit ok);
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    ok = bus.out_valid;
  endtask

  task automatic handshake(input string nm);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk({nm, " out_valid after hs"}, 32'(bus.out_valid), 32'd0);
    chk({nm, " in_ready after hs"}, 32'(bus.in_ready), 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    bit ok;
    issue(v.op, v.a, v.b);
    wait_valid(lat, ok);
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL %s timeout: out_valid=0 want 1", v.name);
    end else begin
      chk(v.name, bus.result, v.exp);
      chk({v.name, " latency"}, 32'(lat), 32'(v.lat));
      handshake(v.name);
    end
  endtask

  initial begin
    int  lat;
    bit  ok;
    bit  seen;
    logic [31:0] held;

    checks        = 0;
    failures      = 0;
    rstn          = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = '0;
    bus.rs1       = '0;
    bus.rs2       = '0;
    bus.out_ready = 1'b0;

    tv[0]  = '{"mul 7*-3",       3'd0, 32'h7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
    tv[1]  = '{"mulhu max*max",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
    tv[2]  = '{"mulh min*min",   3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
    tv[3]  = '{"mulhsu -1*max",  3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
    tv[4]  = '{"div -7/2",       3'd4, 32'hFFFF_FFF9, 32'h2,        32'hFFFF_FFFD, 33};
    tv[5]  = '{"rem -7/2",       3'd6, 32'hFFFF_FFF9, 32'h2,        32'hFFFF_FFFF, 33};
    tv[6]  = '{"divu 100/7",     3'd5, 32'd100,      32'd7,        32'd14,        33};
    tv[7]  = '{"remu 100/7",     3'd7, 32'd100,      32'd7,        32'd2,         33};
    tv[8]  = '{"divu 5/0",       3'd5, 32'd5,        32'd0,        32'hFFFF_FFFF, 1};
    tv[9]  = '{"remu 5/0",       3'd7, 32'd5,        32'd0,        32'd5,         1};
    tv[10] = '{"div ovf",        3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    tv[11] = '{"rem ovf",        3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        1};
    tv[12] = '{"div -7/0",       3'd4, 32'hFFFF_FFF9, 32'h0,        32'hFFFF_FFFF, 1};
    tv[13] = '{"mul x*16",       3'd0, 32'h1234_5678, 32'h10,       32'h2345_6780, 33};
    tv[14] = '{"mulhu x*16",     3'd3, 32'h1234_5678, 32'h10,       32'h1,         33};

    #2;
    chk("reset in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset result", bus.result, 32'd0);
    #6 rstn = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 15; i++) run_vec(tv[i]);

    // Backpressure with a competing request during DONE.
    issue(3'd0, 32'h7, 32'hFFFF_FFFD);
    wait_valid(lat, ok);
    chk("bp out_valid", 32'(ok), 32'd1);
    held = bus.result;
    chk("bp result", held, 32'hFFFF_FFEB);
    bus.op  = 3'd5;
    bus.rs1 = 32'd9;
    bus.rs2 = 32'd0;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      chk("bp stable", bus.result, held);
      chk("bp in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp held valid", 32'(bus.out_valid), 32'd1);
    end
    bus.in_valid = 1'b0;
    handshake("bp");
    @(posedge clk);
    #1;
    chk("bp no stray op", 32'(bus.in_ready), 32'd1);

    // Flush on the 10th CALC cycle.
    issue(3'd0, 32'h12345, 32'h3);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    chk("flush in_ready", 32'(bus.in_ready), 32'd1);
    chk("flush out_valid", 32'(bus.out_valid), 32'd0);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      seen |= bus.out_valid;
    end
    chk("flush no result", 32'(seen), 32'd0);
    run_vec(tv[4]);

    // Flush together with an offered operation.
    bus.op  = 3'd5;
    bus.rs1 = 32'd5;
    bus.rs2 = 32'd0;
    bus.in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    flush = 1'b0;
    chk("flush+in in_ready", 32'(bus.in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("flush+in no valid", 32'(bus.out_valid), 32'd0);

    // Asynchronous reset mid-CALC.
    issue(3'd5, 32'd100, 32'd7);
    repeat (5) @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("arst in_ready", 32'(bus.in_ready), 32'd1);
    chk("arst out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst result", bus.result, 32'd0);
    #2 rstn = 1'b1;
    @(posedge clk);
    #1;
    chk("arst idle", 32'(bus.in_ready), 32'd1);
    run_vec(tv[7]);
    run_vec(tv[9]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
